alu_op_sequencer: RTL

//   Upstream control stage for the 32-bit ALU: fetches 16-bit instruction words from a

---
 rtl/alu_op_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: fetch/decode/execute/write-back controller for an external 32-bit ALU.
// Instructions come from a synchronous ROM. Operands live in a 16-entry register file.
// Each executed instruction takes four cycles: FETCH, DECODE, EXEC and WB.
// rom_addr is loaded on entry to FETCH. The synchronous ROM therefore presents
// the instruction word during DECODE, and DECODE latches it.
module alu_op_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              carry_flag,
   input  logic [3:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_HALT = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_LDI  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;

   state_t              state;
   logic [ADDR_W-1:0]   pc;
   logic [15:0]         ir;
   logic [DATA_W-1:0]   regfile [16];

   // Opcodes with no defined meaning; they stop the program and raise error.
   function automatic logic is_illegal(input logic [3:0] op);
      case (op)
         4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd12, 4'd14: is_illegal = 1'b1;
         default:                                     is_illegal = 1'b0;
      endcase
   endfunction

   // Only ADD and SUB update the carry flag.
   function automatic logic updates_carry(input logic [3:0] op);
      updates_carry = (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // Debug port: asynchronous read of the register file.
   assign dbg_data = regfile[dbg_addr];

   // Sequencer FSM with all outputs and the register file registered in one process.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= '0;
         ir         <= 16'h0000;
         rom_addr   <= '0;
         alu_op     <= 4'd0;
         alu_a      <= '0;
         alu_b      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         carry_flag <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            regfile[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  pc       <= '0;
                  rom_addr <= '0;
                  error    <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_FETCH;
               end else begin
                  state <= state;
               end
            end
            S_FETCH: begin
               rom_addr <= pc;
               state    <= S_DECODE;
            end
            S_DECODE: begin
               ir <= rom_data;
               if (rom_data[15:12] == OP_HALT) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_HALT;
               end else if (is_illegal(rom_data[15:12])) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_HALT;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               // LDI never presents anything to the ALU, so the ALU inputs keep
               // the previous ALU instruction's values.
               if (ir[15:12] != OP_LDI) begin
                  alu_op <= ir[15:12];
                  alu_a  <= regfile[ir[7:4]];
                  alu_b  <= regfile[ir[3:0]];
               end else begin
                  alu_op <= alu_op;
               end
               state <= S_WB;
            end
            S_WB: begin
               if (ir[15:12] == OP_LDI) begin
                  regfile[ir[11:8]] <= DATA_W'(ir[7:0]);
               end else begin
                  regfile[ir[11:8]] <= alu_out;
                  if (updates_carry(ir[15:12])) begin
                     carry_flag <= alu_carry;
                  end else begin
                     carry_flag <= carry_flag;
                  end
               end
               pc       <= pc + ADDR_W'(1'b1);
               rom_addr <= pc + ADDR_W'(1'b1);
               state    <= S_FETCH;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
